// File: rtl/axis_frame_arb.sv
// Frame-aware AXI-Stream arbiter: one source owns the sink from its first beat
// until its tlast beat is accepted, behind a single registered output stage.
module axis_frame_arb #(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int ARB_RR     = 1,
   localparam int SEL_W     = $clog2(S_COUNT)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [S_COUNT-1:0]             s_axis_tvalid,
   output logic [S_COUNT-1:0]             s_axis_tready,
   input  logic [S_COUNT-1:0]             s_axis_tlast,
   input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
   input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
   input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [ID_WIDTH-1:0]            m_axis_tid,
   output logic [DEST_WIDTH-1:0]          m_axis_tdest,
   output logic [USER_WIDTH-1:0]          m_axis_tuser,
   output logic                           grant_valid,
   output logic [SEL_W-1:0]               grant_index
);

   typedef struct packed {
      logic                  last;
      logic [USER_WIDTH-1:0] user;
      logic [DEST_WIDTH-1:0] dest;
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                    state_q, state_d;
   logic [SEL_W-1:0]          grant_q, rr_ptr_q;
   logic [SEL_W-1:0]          rr_win, fp_win, win, idx;
   logic                      rr_found, grant_load;
   logic                      out_ready, beat_acc;
   beat_t [S_COUNT-1:0]       src_beat;
   beat_t                     sel_beat, out_q;
   logic                      out_vld_q;

   for (genvar i = 0; i < S_COUNT; i++) begin : g_port
      assign src_beat[i].data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign src_beat[i].id   = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
      assign src_beat[i].dest = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
      assign src_beat[i].user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      assign src_beat[i].last = s_axis_tlast[i];
      assign s_axis_tready[i] = (state_q == ACTIVE) && (grant_q == SEL_W'(i)) && out_ready;
   end

   // Output register can take a beat when empty or draining this cycle.
   assign out_ready = m_axis_tready || !out_vld_q;
   assign sel_beat  = src_beat[grant_q];
   assign beat_acc  = (state_q == ACTIVE) && s_axis_tvalid[grant_q] && out_ready;

   // Round-robin scans upward from the slot after the last winner.
   always_comb begin
      rr_win   = '0;
      fp_win   = '0;
      rr_found = 1'b0;
      idx      = '0;
      for (int i = S_COUNT-1; i >= 0; i--)
         if (s_axis_tvalid[i]) fp_win = SEL_W'(i);
      for (int k = 1; k <= S_COUNT; k++) begin
         idx = SEL_W'((int'(rr_ptr_q) + k) % S_COUNT);
         if (!rr_found && s_axis_tvalid[idx]) begin
            rr_found = 1'b1;
            rr_win   = idx;
         end
      end
   end

   assign win = (ARB_RR != 0) ? rr_win : fp_win;

   always_comb begin
      state_d    = state_q;
      grant_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (|s_axis_tvalid) begin
               state_d    = ACTIVE;
               grant_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (beat_acc && sel_beat.last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= SEL_W'(S_COUNT-1);
         out_vld_q <= 1'b0;
         out_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant_load) begin
            grant_q <= win;
            if (ARB_RR != 0) rr_ptr_q <= win;
         end
         if (beat_acc) begin
            out_q     <= sel_beat;
            out_vld_q <= 1'b1;
         end else if (m_axis_tready) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign m_axis_tdata  = out_q.data;
   assign m_axis_tid    = out_q.id;
   assign m_axis_tdest  = out_q.dest;
   assign m_axis_tuser  = out_q.user;
   assign m_axis_tlast  = out_q.last;
   assign m_axis_tvalid = out_vld_q;
   assign grant_valid   = (state_q == ACTIVE);
   assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_frame_arb.sv
// Bench for axis_frame_arb: directed and random frames on a round-robin and a
// fixed-priority instance, scored against a frame-level arbitration model.
module tb_axis_frame_arb;

   localparam int S  = 4;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int DSW = 8;
   localparam int UW = 1;
   localparam int SW = $clog2(S);

   typedef struct packed {
      logic          last;
      logic [UW-1:0] user;
      logic [DSW-1:0] dest;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [S*DW-1:0]  s_tdata;
   logic [S-1:0]     s_tvalid, s_tlast;
   logic [S*IW-1:0]  s_tid;
   logic [S*DSW-1:0] s_tdest;
   logic [S*UW-1:0]  s_tuser;
   logic             m_tready;

   logic [S-1:0] rr_tready, fp_tready;
   logic [DW-1:0] rr_tdata, fp_tdata;
   logic [IW-1:0] rr_tid, fp_tid;
   logic [DSW-1:0] rr_tdest, fp_tdest;
   logic [UW-1:0] rr_tuser, fp_tuser;
   logic rr_tvalid, fp_tvalid, rr_tlast, fp_tlast, rr_gvalid, fp_gvalid;
   logic [SW-1:0] rr_gidx, fp_gidx;

   bit sel_fp = 1'b0;
   beat_t rr_beat, fp_beat, o_beat;
   logic [S-1:0] o_tready;
   logic o_mvalid, o_gvalid;
   logic [SW-1:0] o_gidx;

   always #5 clk = ~clk;

   axis_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
                    .USER_WIDTH(UW), .ARB_RR(1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(rr_tready),
      .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(rr_tdata), .m_axis_tvalid(rr_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(rr_tlast), .m_axis_tid(rr_tid), .m_axis_tdest(rr_tdest), .m_axis_tuser(rr_tuser),
      .grant_valid(rr_gvalid), .grant_index(rr_gidx));

   axis_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
                    .USER_WIDTH(UW), .ARB_RR(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(fp_tready),
      .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(fp_tdata), .m_axis_tvalid(fp_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(fp_tlast), .m_axis_tid(fp_tid), .m_axis_tdest(fp_tdest), .m_axis_tuser(fp_tuser),
      .grant_valid(fp_gvalid), .grant_index(fp_gidx));

   assign rr_beat  = {rr_tlast, rr_tuser, rr_tdest, rr_tid, rr_tdata};
   assign fp_beat  = {fp_tlast, fp_tuser, fp_tdest, fp_tid, fp_tdata};
   assign o_beat   = sel_fp ? fp_beat : rr_beat;
   assign o_tready = sel_fp ? fp_tready : rr_tready;
   assign o_mvalid = sel_fp ? fp_tvalid : rr_tvalid;
   assign o_gvalid = sel_fp ? fp_gvalid : rr_gvalid;
   assign o_gidx   = sel_fp ? fp_gidx : rr_gidx;

   int asserts = 0;
   int fails = 0;

   // source-side frame storage and pacing controls
   beat_t mem [S][128];
   beat_t drv_beat [S];
   int nb [S];
   int rd [S];
   int pause_at [S];
   int pause_left [S];
   int gap_pct, ready_pct, exp_gidx, cyc;
   bit rpat[$];
   bit chk_timing, gv_seen;
   beat_t exp_q[$];
   beat_t got_q[$];
   int ord_q[$];

   bit prev_hs, prev_stall, last_mvalid, last_hs_last;
   beat_t prev_beat, prev_out;
   int last_hs_cyc, stall_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      asserts++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_src();
      for (int p = 0; p < S; p++) begin
         nb[p] = 0; rd[p] = 0; pause_at[p] = -1; pause_left[p] = 0; drv_beat[p] = '0;
      end
      rpat.delete(); exp_q.delete(); got_q.delete(); ord_q.delete();
      gap_pct = 0; ready_pct = 100; exp_gidx = -1; chk_timing = 1'b0; gv_seen = 1'b0;
      prev_hs = 1'b0; prev_stall = 1'b0; last_mvalid = 1'b0; last_hs_cyc = -1;
      last_hs_last = 1'b0; stall_seen = 0;
   endtask

   task automatic reset_all();
      s_tvalid = '0; m_tready = 1'b0; rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_src();
   endtask

   task automatic add_frame(input int p, input int len, input logic [7:0] d0, input logic [7:0] dstep);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = d0 + 8'(k) * dstep;
         b.id   = 8'(p);
         b.dest = 8'($urandom);
         b.user = 1'($urandom);
         b.last = (k == len-1);
         mem[p][nb[p]] = b;
         nb[p]++;
      end
   endtask

   // Frame-level model: every source with frames left requests at each
   // arbitration point; whole frames are emitted in grant order.
   task automatic build_expected(input bit fp);
      int pos [S];
      int ptr, win;
      bit more;
      exp_q.delete();
      ptr = S-1;
      for (int p = 0; p < S; p++) pos[p] = 0;
      more = 1'b1;
      while (more) begin
         win = -1;
         for (int k = 1; k <= S; k++) begin
            int j;
            j = fp ? k-1 : (ptr + k) % S;
            if (win < 0 && pos[j] < nb[j]) win = j;
         end
         if (win < 0) more = 1'b0;
         else begin
            ptr = win;
            do begin
               exp_q.push_back(mem[win][pos[win]]);
               pos[win]++;
            end while (!mem[win][pos[win]-1].last);
         end
      end
   endtask

   task automatic drive();
      beat_t b;
      bit v, first;
      for (int p = 0; p < S; p++) begin
         v = 1'b0; b = '0;
         if (rd[p] < nb[p]) begin
            b = mem[p][rd[p]]; v = 1'b1;
            if (rd[p] == 0) first = 1'b1;
            else first = mem[p][rd[p]-1].last;
            if (!first) begin
               if (pause_at[p] == rd[p] && pause_left[p] > 0) begin
                  v = 1'b0; pause_left[p]--;
               end else if (int'($urandom_range(0, 99)) < gap_pct) v = 1'b0;
            end
         end
         drv_beat[p] = b;
         s_tvalid[p] = v;
         s_tlast[p]  = b.last;
         s_tdata[p*DW +: DW]   = b.data;
         s_tid[p*IW +: IW]     = b.id;
         s_tdest[p*DSW +: DSW] = b.dest;
         s_tuser[p*UW +: UW]   = b.user;
      end
      if (rpat.size() > 0) m_tready = rpat.pop_front();
      else m_tready = (int'($urandom_range(0, 99)) < ready_pct);
   endtask

   task automatic step();
      logic [S-1:0] hs, gmask;
      int hp;
      drive();
      @(negedge clk);
      hs = s_tvalid & o_tready;
      hp = -1;
      for (int p = 0; p < S; p++) begin
         if (hs[p]) hp = p;
         gmask[p] = o_gvalid && (o_gidx == SW'(p));
      end
      chk("one_handshake", 32'($countones(hs) <= 1), 32'd1);
      chk("ungranted_ready", 32'(o_tready & ~gmask), 32'd0);
      if (o_mvalid && !m_tready) chk("full_ready", 32'(o_tready), 32'd0);
      if (prev_hs) begin
         chk("latency_valid", 32'(o_mvalid), 32'd1);
         chk("latency_beat", 32'(o_beat), 32'(prev_beat));
      end
      if (prev_stall) begin
         chk("stall_valid", 32'(o_mvalid), 32'd1);
         chk("stall_hold", 32'(o_beat), 32'(prev_out));
         stall_seen++;
      end
      if (exp_gidx >= 0 && o_gvalid) chk("grant_index", 32'(o_gidx), 32'(exp_gidx));
      if (o_gvalid) gv_seen = 1'b1;
      if (hp >= 0) begin
         if (chk_timing && last_hs_cyc >= 0)
            chk("beat_spacing", 32'(cyc - last_hs_cyc), last_hs_last ? 32'd2 : 32'd1);
         last_hs_cyc  = cyc;
         last_hs_last = drv_beat[hp].last;
         prev_beat    = drv_beat[hp];
      end
      prev_hs     = (hp >= 0);
      prev_stall  = o_mvalid && !m_tready;
      prev_out    = o_beat;
      last_mvalid = o_mvalid;
      if (o_mvalid && m_tready) got_q.push_back(o_beat);
      @(posedge clk); #1;
      if (hp >= 0) rd[hp]++;
      cyc++;
   endtask

   function automatic bit all_sent();
      for (int p = 0; p < S; p++) if (rd[p] != nb[p]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic beat_t got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return '1;
   endfunction

   task automatic run(input bit fp, input int budget);
      int n;
      bit done;
      sel_fp = fp;
      build_expected(fp);
      n = 0; done = 1'b0;
      while (!done && n < budget) begin
         step();
         n++;
         done = all_sent() && (got_q.size() >= exp_q.size()) && !last_mvalid;
      end
      chk("run_done", 32'(done), 32'd1);
      chk("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) chk("beat", 32'(got_at(i)), 32'(exp_q[i]));
      ord_q.delete();
      for (int i = 0; i < got_q.size(); i++)
         if (i == 0 || got_q[i-1].last) ord_q.push_back(int'(got_q[i].id));
   endtask

   function automatic int ord_at(input int i);
      if (i < ord_q.size()) return ord_q[i];
      return -1;
   endfunction

   initial begin
      beat_t g;
      int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
      int fp_exp [4] = '{1, 1, 3, 3};
      cyc = 0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tid = '0; s_tdest = '0; s_tuser = '0;
      m_tready = 1'b0;
      clear_src();

      // asynchronous reset from power-up
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mvalid", 32'(o_mvalid), 32'd0);
      chk("rst_tready", 32'(o_tready), 32'd0);
      chk("rst_gvalid", 32'(o_gvalid), 32'd0);
      chk("rst_gidx", 32'(o_gidx), 32'd0);

      // single 3-beat frame on port 2
      reset_all();
      chk_timing = 1'b1; exp_gidx = 2;
      add_frame(2, 3, 8'h11, 8'h11);
      run(1'b0, 50);
      g = got_at(0); chk("single_d0", 32'(g.data), 32'h11);
      g = got_at(1); chk("single_d1", 32'(g.data), 32'h22);
      g = got_at(2); chk("single_d2", 32'(g.data), 32'h33);
      chk("single_last", 32'(g.last), 32'd1);
      chk("single_granted", 32'(gv_seen), 32'd1);
      chk("single_idle_after", 32'(o_gvalid), 32'd0);

      // round-robin fairness across ports 0,1,3
      reset_all();
      chk_timing = 1'b1;
      for (int f = 0; f < 2; f++) begin
         add_frame(0, 2, 8'($urandom), 8'd1);
         add_frame(1, 2, 8'($urandom), 8'd1);
         add_frame(3, 2, 8'($urandom), 8'd1);
      end
      run(1'b0, 200);
      chk("rr_frames", 32'(ord_q.size()), 32'd6);
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(ord_at(k)), 32'(rr_exp[k]));

      // fixed priority: port 1 beats port 3 while it keeps requesting
      reset_all();
      chk_timing = 1'b1;
      for (int f = 0; f < 2; f++) begin
         add_frame(1, 2, 8'($urandom), 8'd3);
         add_frame(3, 2, 8'($urandom), 8'd3);
      end
      run(1'b1, 200);
      for (int k = 0; k < 4; k++) chk("fp_order", 32'(ord_at(k)), 32'(fp_exp[k]));

      // backpressure during a 4-beat frame with port 1 waiting
      reset_all();
      rpat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      add_frame(0, 4, 8'hA0, 8'h01);
      add_frame(1, 2, 8'h50, 8'h01);
      run(1'b0, 100);
      chk("bp_stalled", 32'(stall_seen > 0), 32'd1);
      chk("bp_order0", 32'(ord_at(0)), 32'd0);
      chk("bp_order1", 32'(ord_at(1)), 32'd1);

      // source pauses mid-frame; the other requester must wait for tlast
      reset_all();
      add_frame(0, 4, 8'h10, 8'h01);
      add_frame(1, 2, 8'h20, 8'h01);
      pause_at[0] = 2; pause_left[0] = 5;
      run(1'b0, 100);
      chk("pause_used", 32'(pause_left[0]), 32'd0);
      chk("pause_order0", 32'(ord_at(0)), 32'd0);
      chk("pause_order1", 32'(ord_at(1)), 32'd1);

      // random frames, gaps and backpressure on both arbitration modes
      for (int it = 0; it < 8; it++) begin
         reset_all();
         gap_pct = 20; ready_pct = 70;
         for (int p = 0; p < S; p++) begin
            int nf;
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++)
               add_frame(p, int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom));
         end
         run(it[0], 3000);
      end

      // reset in the middle of a frame
      reset_all();
      sel_fp = 1'b0;
      add_frame(0, 6, 8'h60, 8'h01);
      add_frame(1, 2, 8'h70, 8'h01);
      repeat (4) step();
      chk("pre_rst_mvalid", 32'(o_mvalid), 32'd1);
      chk("pre_rst_gvalid", 32'(o_gvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mvalid", 32'(o_mvalid), 32'd0);
      chk("midrst_tready", 32'(o_tready), 32'd0);
      chk("midrst_gvalid", 32'(o_gvalid), 32'd0);
      reset_all();
      add_frame(1, 2, 8'h81, 8'h01);
      add_frame(2, 2, 8'h91, 8'h01);
      add_frame(0, 2, 8'hA1, 8'h01);
      run(1'b0, 100);
      chk("post_rst_first", 32'(ord_at(0)), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
